kamus_l1d_arbiter: RTL and testbench
====================================

Name: kamus_l1d_arbiter

Overview:
Shares the single L1 data-cache port between the instruction-fetch requester (IF, read-only) and the load/store requester (LSU, read/write). It sits between the core pipeline and the L1D/memory interface. It uses a request/grant/response protocol with one outstanding transaction, and returns read data and completion to the owning requester. It also screens LSU misaligned accesses before they reach memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte-enable width is DATA_W/8
LSU_PRIO, 1, 1 = LSU wins when both requesters assert on the same cycle; 0 = IF wins

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
if_req_i  in  1  IF read request; held with its address until if_gnt_o
if_addr_i  in  ADDR_W  IF read address
if_gnt_o  out  1  IF request accepted by memory (1-cycle pulse)
if_rvalid_o  out  1  IF response valid (1-cycle pulse)
if_rdata_o  out  DATA_W  IF read data
lsu_req_i  in  1  LSU request; held with all fields until lsu_gnt_o
lsu_we_i  in  1  1 = store, 0 = load
lsu_be_i  in  DATA_W/8  byte enables
lsu_addr_i  in  ADDR_W  LSU address
lsu_wdata_i  in  DATA_W  store data
lsu_gnt_o  out  1  LSU request accepted (1-cycle pulse)
lsu_rvalid_o  out  1  LSU response valid; also pulses for stores
lsu_rdata_o  out  DATA_W  LSU load data
lsu_err_o  out  1  misaligned error; valid with lsu_rvalid_o
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_W/8  memory byte enables
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_gnt_i  in  1  memory accepts the request this cycle
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset: state IDLE, owner cleared, latched fields zero. All outputs are 0.
- FSM states: IDLE, REQ, WAIT_RSP, ERR_RSP.
- IDLE: if any request is asserted, select the winner. Simultaneous requests resolve per LSU_PRIO (or per the Optional Feature). Latch owner, we, be, addr and wdata. IF requests latch we=0 and be=all-ones.
  - Winner is LSU and misaligned: go to ERR_RSP.
  - Otherwise: go to REQ.
- Misaligned is defined as be all-ones with addr[1:0]!=0, or be 0011/1100 with addr[0]!=0.
- REQ:
  - mem_req_o=1; mem_* outputs are driven from the latched registers and are stable.
  - On mem_gnt_i, pulse the owner's gnt_o that same cycle (combinational from mem_gnt_i and state) and go to WAIT_RSP.
  - mem_req_o stays high until granted.
- WAIT_RSP:
  - mem_req_o=0.
  - On mem_rvalid_i, drive the owner's rvalid_o=1 and rdata_o=mem_rdata_i in the same cycle, then go to IDLE.
  - Stores also complete via rvalid, with rdata ignored.
- ERR_RSP: pulse lsu_gnt_o, lsu_rvalid_o and lsu_err_o together for one cycle; mem_req_o stays 0; go to IDLE.
- Latency: minimum 3 cycles from requester assert to rvalid (IDLE→REQ, gnt, rvalid). A new arbitration can start the cycle after rvalid.
- Losing requester: keeps its request asserted and is evaluated again in the next IDLE.
- Response data: rdata_o is 0 whenever the corresponding rvalid_o is 0. The non-owner's gnt/rvalid never pulse.
- mem_rvalid_i while in IDLE or REQ: ignored. This covers a stale response after reset.
- Reset in any state: immediate return to IDLE and the outstanding transaction is dropped. Requesters must reissue.
- Requester drops req before gnt: protocol violation. Behaviour is undefined, but the FSM must still recover via reset.

Optional Feature:
- Macro: KAMUS_L1D_ARB_RR_EN.
- Defined:
  - A 1-bit last-owner register (reset = IF) controls simultaneous requests: the requester that was not the last owner wins, and LSU_PRIO is ignored.
  - The register updates on every completed transaction, including ERR_RSP.
- Undefined: fixed priority per LSU_PRIO; no last-owner register.

Decomposition:
- kamus_pkg: l1d_arb_state_e (IDLE, REQ, WAIT_RSP, ERR_RSP), l1d_owner_e (OWNER_IF, OWNER_LSU), and a misalignment check function.
- Sub-module kamus_l1d_arb_pick: combinational winner select. Inputs: the two request lines, LSU_PRIO, and the last owner. Output: winner.
- FSM, latches and response routing stay in the top module.

Test Plan:
- Single IF read, addr 0x100: mem_gnt_i on the first REQ cycle, mem_rvalid_i next cycle with 0xDEADBEEF → if_gnt_o pulse, then if_rvalid_o=1 with if_rdata_o=0xDEADBEEF; lsu_* all 0.
- Simultaneous IF (0x40) and LSU load (0x80), LSU_PRIO=1 → LSU transaction first with mem_addr_o=0x80, then IF with 0x40. With KAMUS_L1D_ARB_RR_EN and a prior LSU owner → IF first.
- LSU store, be=1111, addr=0x203 → no mem_req_o; lsu_gnt_o, lsu_rvalid_o and lsu_err_o high for one cycle, two cycles after request.
- mem_gnt_i held low 5 cycles in REQ → mem_req_o and mem_addr_o/mem_wdata_o/mem_be_o stable all 5 cycles; gnt pulses only when mem_gnt_i rises.
- rst_i asserted in WAIT_RSP, then mem_rvalid_i arrives → no rvalid on either requester; FSM in IDLE; next request served normally.
- LSU store 0x12345678, be=0011, addr=0x10 → mem_we_o=1, mem_be_o=0011, mem_wdata_o=0x12345678; lsu_rvalid_o=1 with lsu_err_o=0 on mem_rvalid_i.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared types for the Kamus L1D arbiter: FSM states, requester identities and
// the LSU misalignment rule (word needs addr[1:0]==0, halfword needs addr[0]==0).
package kamus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    ERR_RSP
  } l1d_arb_state_e;

  typedef enum logic {
    OWNER_IF,
    OWNER_LSU
  } l1d_owner_e;

  function automatic logic isMisaligned(input logic [3:0] be, input logic [1:0] addrLo);
    isMisaligned = ((be == 4'b1111) && (addrLo != 2'b00)) ||
                   (((be == 4'b0011) || (be == 4'b1100)) && addrLo[0]);
  endfunction

endpackage

// File: rtl/kamus_l1d_arb_pick.sv
// Combinational winner select between IF and LSU requests.
// With KAMUS_L1D_ARB_RR_EN defined, ties go to whoever was not the last owner.
module kamus_l1d_arb_pick
  import kamus_pkg::*;
#(
  parameter int unsigned LSU_PRIO = 1
) (
  input  logic       ifReq_i,
  input  logic       lsuReq_i,
  input  l1d_owner_e lastOwner_i,
  output l1d_owner_e winner_o
);

  logic tieToLsu;

`ifdef KAMUS_L1D_ARB_RR_EN
  assign tieToLsu = (lastOwner_i == OWNER_IF);
`else
  logic unusedLastOwner;
  assign unusedLastOwner = (lastOwner_i == OWNER_LSU);
  assign tieToLsu = (LSU_PRIO != 0);
`endif

  always_comb begin
    winner_o = OWNER_IF;
    if (lsuReq_i && (!ifReq_i || tieToLsu)) begin
      winner_o = OWNER_LSU;
    end
  end

endmodule

// File: rtl/kamus_l1d_arbiter.sv
// Shares one L1D port between IF and LSU with a single outstanding transaction.
// Optional round-robin tie-break: define KAMUS_L1D_ARB_RR_EN.
module kamus_l1d_arbiter
  import kamus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LSU_PRIO = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned BE_W = DATA_W / 8;

  l1d_arb_state_e      state_q, state_d;
  l1d_owner_e          owner_q, owner_d;
  l1d_owner_e          lastOwner, winner;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                lsuMisaligned;

  assign lsuMisaligned = isMisaligned(lsu_be_i[3:0], lsu_addr_i[1:0]);

  kamus_l1d_arb_pick #(
    .LSU_PRIO(LSU_PRIO)
  ) u_pick (
    .ifReq_i    (if_req_i),
    .lsuReq_i   (lsu_req_i),
    .lastOwner_i(lastOwner),
    .winner_o   (winner)
  );

`ifdef KAMUS_L1D_ARB_RR_EN
  // Remember who completed last, error responses included, to alternate on ties.
  l1d_owner_e lastOwner_q;
  logic       txnDone;

  assign txnDone = ((state_q == WAIT_RSP) && mem_rvalid_i) || (state_q == ERR_RSP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastOwner_q <= OWNER_IF;
    end else if (txnDone) begin
      lastOwner_q <= owner_q;
    end
  end

  assign lastOwner = lastOwner_q;
`else
  assign lastOwner = OWNER_IF;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWNER_IF;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_gnt_o     = 1'b0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    lsu_gnt_o    = 1'b0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = '0;
    lsu_err_o    = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;

    unique case (state_q)
      IDLE: begin
        if (if_req_i || lsu_req_i) begin
          owner_d = winner;
          if (winner == OWNER_LSU) begin
            we_d    = lsu_we_i;
            be_d    = lsu_be_i;
            addr_d  = lsu_addr_i;
            wdata_d = lsu_wdata_i;
            state_d = lsuMisaligned ? ERR_RSP : REQ;
          end else begin
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = if_addr_i;
            wdata_d = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_gnt_i) begin
          if_gnt_o  = (owner_q == OWNER_IF);
          lsu_gnt_o = (owner_q == OWNER_LSU);
          state_d   = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid_i) begin
          if (owner_q == OWNER_IF) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end else begin
            lsu_rvalid_o = 1'b1;
            lsu_rdata_o  = mem_rdata_i;
          end
          state_d = IDLE;
        end
      end
      ERR_RSP: begin
        // Misaligned LSU access is answered locally without touching memory.
        lsu_gnt_o    = 1'b1;
        lsu_rvalid_o = 1'b1;
        lsu_err_o    = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_kamus_l1d_arbiter.sv
// Self-checking bench for kamus_l1d_arbiter: vector table, corner sequences and
// randomized traffic against a transaction-timeline reference model.
module tb_kamus_l1d_arbiter;

  localparam int unsigned LSU_PRIO = 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  kamus_l1d_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LSU_PRIO(LSU_PRIO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    bit          isLsu;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    bit          expErr;
    int          expLat;
  } vec_t;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  bit          ifPend, lsuPend, lsuWe;
  logic [31:0] ifAddr, lsuAddr, lsuWdata;
  logic [3:0]  lsuBe;

  // Reference timeline of the transaction in flight, in absolute cycle numbers.
  bit          busy, isErr, ownerLsu, lastLsu;
  bit          tWe;
  logic [3:0]  tBe;
  logic [31:0] tAddr, tWdata;
  int          tReq, tGnt, tRsp, tErr, tFree;
  int          gntDelayCfg, rspDelayCfg;
  bit          randDelay, randSpur, forceRvalid, useRdataCfg;
  logic [31:0] rdataCfg, rspData;

  bit          rspSeen, rspLsu, rspErr;
  int          rspCycle;
  logic [31:0] rspRdata;
  logic [31:0] grantAddrs[$];

  function automatic bit lsuWins(input bit ifR, input bit lsuR, input bit lastWasLsu);
    if (!lsuR) return 1'b0;
    if (!ifR) return 1'b1;
`ifdef KAMUS_L1D_ARB_RR_EN
    return !lastWasLsu;
`else
    return (LSU_PRIO != 0);
`endif
  endfunction

  function automatic bit misaligned(input logic [3:0] be, input logic [31:0] addr);
    int unsigned a;
    a = addr;
    if (be == 4'hF) return (a % 4) != 0;
    if (be == 4'h3 || be == 4'hC) return (a % 2) != 0;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: arbitrate in the model, drive inputs, compare every output.
  task automatic applyStimulus();
    logic [138:0] expV, actV;
    bit memReqE, spurOk, ifG, lsuG, ifRv, lsuRv, lsuE;
    int gd, rd;
    @(negedge clk_i);
    cyc++;
    if (!busy && (ifPend || lsuPend)) begin
      ownerLsu = lsuWins(ifPend, lsuPend, lastLsu);
      busy = 1'b1;
      if (ownerLsu) begin
        tWe = lsuWe; tBe = lsuBe; tAddr = lsuAddr; tWdata = lsuWdata;
      end else begin
        tWe = 1'b0; tBe = 4'hF; tAddr = ifAddr; tWdata = 32'h0;
      end
      isErr = ownerLsu && misaligned(tBe, tAddr);
      if (isErr) begin
        tErr = cyc + 1; tFree = cyc + 2; tReq = -1; tGnt = -1; tRsp = -1;
      end else begin
        gd = randDelay ? int'($urandom_range(3, 0)) : gntDelayCfg;
        rd = randDelay ? int'($urandom_range(3, 0)) : rspDelayCfg;
        tReq = cyc + 1; tGnt = tReq + gd; tRsp = tGnt + 1 + rd; tFree = tRsp + 1; tErr = -1;
      end
    end
    if_req_i    = ifPend;
    if_addr_i   = ifAddr;
    lsu_req_i   = lsuPend;
    lsu_we_i    = lsuWe;
    lsu_be_i    = lsuBe;
    lsu_addr_i  = lsuAddr;
    lsu_wdata_i = lsuWdata;
    mem_gnt_i   = busy && (cyc == tGnt);
    rspData     = (busy && cyc == tRsp && useRdataCfg) ? rdataCfg : $urandom;
    mem_rdata_i = rspData;
    spurOk      = !busy || (!isErr && cyc <= tGnt);
    mem_rvalid_i = (busy && cyc == tRsp) ||
                   (spurOk && (forceRvalid || (randSpur && $urandom_range(3, 0) == 0)));
    forceRvalid = 1'b0;

    memReqE = busy && !isErr && cyc >= tReq && cyc <= tGnt;
    ifG     = busy && !ownerLsu && cyc == tGnt;
    lsuG    = busy && ownerLsu && (cyc == tGnt || cyc == tErr);
    ifRv    = busy && !ownerLsu && cyc == tRsp;
    lsuRv   = busy && ownerLsu && (cyc == tRsp || cyc == tErr);
    lsuE    = busy && isErr && cyc == tErr;
    expV = {ifG, ifRv, ifRv ? rspData : 32'h0,
            lsuG, lsuRv, (lsuRv && !lsuE) ? rspData : 32'h0, lsuE,
            memReqE, memReqE ? tWe : 1'b0, memReqE ? tBe : 4'h0,
            memReqE ? tAddr : 32'h0, memReqE ? tWdata : 32'h0};
    #1;
    actV = {if_gnt_o, if_rvalid_o, if_rdata_o, lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
            lsu_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o};
    checkOutput("outputs", {21'h0, actV}, {21'h0, expV});

    if (if_rvalid_o || lsu_rvalid_o) begin
      rspSeen = 1'b1; rspLsu = lsu_rvalid_o; rspErr = lsu_err_o; rspCycle = cyc;
      rspRdata = lsu_rvalid_o ? lsu_rdata_o : if_rdata_o;
    end
    if (mem_req_o && mem_gnt_i) grantAddrs.push_back(mem_addr_o);

    if (busy && (cyc == tGnt || cyc == tErr)) begin
      if (ownerLsu) lsuPend = 1'b0;
      else ifPend = 1'b0;
    end
    if (busy && cyc + 1 == tFree) begin
      busy = 1'b0;
      lastLsu = ownerLsu;
    end
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1; if_req_i = 1'b0; lsu_req_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    busy = 1'b0; ifPend = 1'b0; lsuPend = 1'b0; lastLsu = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string name);
    int startCyc;
    if (v.isLsu) begin
      lsuPend = 1'b1; lsuWe = v.we; lsuBe = v.be; lsuAddr = v.addr; lsuWdata = v.wdata;
    end else begin
      ifPend = 1'b1; ifAddr = v.addr;
    end
    gntDelayCfg = v.gd; rspDelayCfg = v.rd; rdataCfg = v.rdata; useRdataCfg = 1'b1;
    rspSeen = 1'b0;
    startCyc = cyc + 1;
    for (int i = 0; i < 40 && !rspSeen; i++) applyStimulus();
    checkOutput({name, "_rsp_seen"}, 160'(rspSeen), 160'(1));
    checkOutput({name, "_owner"}, 160'(rspLsu), 160'(v.isLsu));
    checkOutput({name, "_err"}, 160'(rspErr), 160'(v.expErr));
    checkOutput({name, "_rdata"}, 160'(rspRdata), 160'(v.expErr ? 32'h0 : v.rdata));
    checkOutput({name, "_latency"}, 160'(rspCycle - startCyc), 160'(v.expLat));
  endtask

  vec_t vecs[11];
  logic [3:0] beList[8];

  initial begin
    vecs[0]  = '{0, 0, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 2};
    vecs[1]  = '{1, 0, 4'hF, 32'h080, 32'h0,        32'h0BADF00D, 1, 2, 0, 5};
    vecs[2]  = '{1, 1, 4'hF, 32'h203, 32'hCAFE0001, 32'h0,        0, 0, 1, 1};
    vecs[3]  = '{1, 1, 4'h3, 32'h010, 32'h12345678, 32'h0,        0, 0, 0, 2};
    vecs[4]  = '{1, 0, 4'h3, 32'h011, 32'h0,        32'h0,        0, 0, 1, 1};
    vecs[5]  = '{1, 0, 4'hC, 32'h012, 32'h0,        32'h55AA55AA, 0, 1, 0, 3};
    vecs[6]  = '{1, 1, 4'hC, 32'h013, 32'h0000BEEF, 32'h0,        0, 0, 1, 1};
    vecs[7]  = '{1, 0, 4'h1, 32'h013, 32'h0,        32'h000000A5, 2, 0, 0, 4};
    vecs[8]  = '{1, 0, 4'hF, 32'h002, 32'h0,        32'h0,        0, 0, 1, 1};
    vecs[9]  = '{0, 0, 4'hF, 32'h103, 32'h0,        32'h13572468, 0, 0, 0, 2};
    vecs[10] = '{1, 1, 4'hF, 32'h400, 32'hA5A5A5A5, 32'h0,        5, 1, 0, 8};
    beList = '{4'hF, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    ifPend = 0; lsuPend = 0; lsuWe = 0; lsuBe = 0; ifAddr = 0; lsuAddr = 0; lsuWdata = 0;
    busy = 0; isErr = 0; ownerLsu = 0; lastLsu = 0;
    tReq = -1; tGnt = -1; tRsp = -1; tErr = -1; tFree = -1;
    randDelay = 0; randSpur = 0; forceRvalid = 0; useRdataCfg = 0;
    if_addr_i = 0; lsu_we_i = 0; lsu_be_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; mem_rdata_i = 0;
    doReset();
    applyStimulus();

    for (int i = 0; i < 11; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests after an LSU-owned transaction.
    runVector('{1, 0, 4'hF, 32'h008, 32'h0, 32'h11112222, 0, 0, 0, 2}, "pre_lsu");
    grantAddrs.delete();
    ifPend = 1; ifAddr = 32'h40;
    lsuPend = 1; lsuWe = 0; lsuBe = 4'hF; lsuAddr = 32'h80;
    gntDelayCfg = 0; rspDelayCfg = 0;
    for (int i = 0; i < 40 && (busy || ifPend || lsuPend); i++) applyStimulus();
    checkOutput("tie_count", 160'(grantAddrs.size()), 160'(2));
`ifdef KAMUS_L1D_ARB_RR_EN
    checkOutput("tie_first", 160'(grantAddrs[0]), 160'(32'h40));
    checkOutput("tie_second", 160'(grantAddrs[1]), 160'(32'h80));
`else
    checkOutput("tie_first", 160'(grantAddrs[0]), 160'(32'h80));
    checkOutput("tie_second", 160'(grantAddrs[1]), 160'(32'h40));
`endif

    // Reset while waiting for a response, then a late response must be dropped.
    lsuPend = 1; lsuWe = 0; lsuBe = 4'hF; lsuAddr = 32'h44;
    gntDelayCfg = 0; rspDelayCfg = 3;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    doReset();
    rspSeen = 1'b0;
    forceRvalid = 1'b1;
    applyStimulus();
    checkOutput("no_rsp_after_reset", 160'(rspSeen), 160'(0));
    runVector('{0, 0, 4'hF, 32'h300, 32'h0, 32'h87654321, 0, 0, 0, 2}, "after_reset");

    // Randomized traffic with random memory delays and stray responses.
    randDelay = 1; randSpur = 1; useRdataCfg = 0;
    for (int i = 0; i < 800; i++) begin
      if (!ifPend && $urandom_range(2, 0) == 0) begin
        ifPend = 1; ifAddr = $urandom;
      end
      if (!lsuPend && $urandom_range(2, 0) == 0) begin
        lsuPend = 1; lsuWe = 1'($urandom); lsuBe = beList[$urandom_range(7, 0)];
        lsuAddr = $urandom; lsuWdata = $urandom;
      end
      applyStimulus();
    end
    for (int i = 0; i < 60 && (busy || ifPend || lsuPend); i++) applyStimulus();
    checkOutput("random_drained", 160'({busy, ifPend, lsuPend}), 160'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
